// File: rtl/uart_rx_if.sv
// Byte handshake between the UART receiver and its consumer.
// The receiver drives a one-entry holding buffer (rx_data/rx_valid).
// The consumer accepts a byte with rx_ready.
interface uart_rx_if;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx.sv
// UART receive stage (8N1, LSB first).
// - Synchronises rx_pin through two flops.
// - Validates the start bit at mid-bit and samples 8 data bits at mid-bit.
// - Checks the stop bit.
// - Hands each byte to the consumer through a one-entry valid/ready buffer.
// - Reports framing errors and overrun errors as one-cycle pulses.
module uart_rx #(
    parameter int CLK_FREQUENCY = 50_000_000,
    parameter int BAUD_RATE     = 115200
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic         rx_pin,
    uart_rx_if.master    rx_bus,
    output logic         frame_err,
    output logic         overrun_err,
    output logic         rx_busy
);

    localparam int CLKS_PER_BIT = CLK_FREQUENCY / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CNT_W        = $clog2(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);

    // Too few clocks per bit leaves no room for the mid-bit sampling point.
    generate
        if (CLKS_PER_BIT < 4) begin : g_illegal_clks_per_bit
            $error("uart_rx: CLK_FREQUENCY/BAUD_RATE must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } state_t;

    logic             rx_meta_r;
    logic             rx_s_r;
    state_t           state_r;
    state_t           state_nxt_s;
    logic [CNT_W-1:0] clk_cnt_r;
    logic [CNT_W-1:0] clk_cnt_nxt_s;
    logic [2:0]       bit_idx_r;
    logic [2:0]       bit_idx_nxt_s;
    logic [7:0]       shift_r;
    logic [7:0]       shift_nxt_s;
    logic             byte_done_s;
    logic             frame_bad_s;
    logic [7:0]       rx_data_r;
    logic [7:0]       rx_data_nxt_s;
    logic             rx_valid_r;
    logic             rx_valid_nxt_s;
    logic             frame_err_r;
    logic             overrun_err_r;
    logic             overrun_nxt_s;
    logic             rx_busy_r;

    // Two-flop synchroniser on the asynchronous line; idles high out of reset.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            rx_meta_r <= 1'b1;
            rx_s_r    <= 1'b1;
        end else begin
            rx_meta_r <= rx_pin;
            rx_s_r    <= rx_meta_r;
        end
    end

    // Frame FSM: next state, bit timing counter and shift register updates.
    always_comb begin
        state_nxt_s   = state_r;
        clk_cnt_nxt_s = clk_cnt_r;
        bit_idx_nxt_s = bit_idx_r;
        shift_nxt_s   = shift_r;
        byte_done_s   = 1'b0;
        frame_bad_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                clk_cnt_nxt_s = CNT_ZERO;
                if (!rx_s_r) begin
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (clk_cnt_r == HALF_LAST) begin
                    clk_cnt_nxt_s = CNT_ZERO;
                    if (!rx_s_r) begin
                        state_nxt_s   = ST_DATA;
                        bit_idx_nxt_s = 3'd0;
                    end else begin
                        // Line went back high before mid-start: a glitch.
                        state_nxt_s = ST_IDLE;
                    end
                end else begin
                    clk_cnt_nxt_s = clk_cnt_r + CNT_ONE;
                end
            end
            ST_DATA: begin
                if (clk_cnt_r == BIT_LAST) begin
                    clk_cnt_nxt_s          = CNT_ZERO;
                    shift_nxt_s[bit_idx_r] = rx_s_r;
                    if (bit_idx_r == 3'd7) begin
                        state_nxt_s = ST_STOP;
                    end else begin
                        bit_idx_nxt_s = bit_idx_r + 3'd1;
                    end
                end else begin
                    clk_cnt_nxt_s = clk_cnt_r + CNT_ONE;
                end
            end
            ST_STOP: begin
                if (clk_cnt_r == BIT_LAST) begin
                    clk_cnt_nxt_s = CNT_ZERO;
                    if (rx_s_r) begin
                        // Going straight to IDLE lets a back-to-back start be caught next cycle.
                        byte_done_s = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        frame_bad_s = 1'b1;
                        state_nxt_s = ST_BREAK;
                    end
                end else begin
                    clk_cnt_nxt_s = clk_cnt_r + CNT_ONE;
                end
            end
            ST_BREAK: begin
                // Hold off until the line returns high so a held-low line cannot re-arm.
                clk_cnt_nxt_s = CNT_ZERO;
                if (rx_s_r) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_BREAK;
                end
            end
            default: begin
                state_nxt_s   = ST_IDLE;
                clk_cnt_nxt_s = CNT_ZERO;
                bit_idx_nxt_s = 3'd0;
            end
        endcase
    end

    // Holding buffer: load on byte completion unless still full and not draining.
    always_comb begin
        rx_data_nxt_s  = rx_data_r;
        rx_valid_nxt_s = rx_valid_r;
        overrun_nxt_s  = 1'b0;
        if (byte_done_s) begin
            if (!rx_valid_r || rx_bus.rx_ready) begin
                rx_data_nxt_s  = shift_r;
                rx_valid_nxt_s = 1'b1;
            end else begin
                overrun_nxt_s = 1'b1;
            end
        end else if (rx_valid_r && rx_bus.rx_ready) begin
            rx_valid_nxt_s = 1'b0;
        end else begin
            rx_valid_nxt_s = rx_valid_r;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_r       <= ST_IDLE;
            clk_cnt_r     <= CNT_ZERO;
            bit_idx_r     <= 3'd0;
            shift_r       <= 8'h00;
            rx_data_r     <= 8'h00;
            rx_valid_r    <= 1'b0;
            frame_err_r   <= 1'b0;
            overrun_err_r <= 1'b0;
            rx_busy_r     <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            clk_cnt_r     <= clk_cnt_nxt_s;
            bit_idx_r     <= bit_idx_nxt_s;
            shift_r       <= shift_nxt_s;
            rx_data_r     <= rx_data_nxt_s;
            rx_valid_r    <= rx_valid_nxt_s;
            frame_err_r   <= frame_bad_s;
            overrun_err_r <= overrun_nxt_s;
            rx_busy_r     <= (state_nxt_s != ST_IDLE);
        end
    end

    assign rx_bus.rx_data  = rx_data_r;
    assign rx_bus.rx_valid = rx_valid_r;
    assign frame_err       = frame_err_r;
    assign overrun_err     = overrun_err_r;
    assign rx_busy         = rx_busy_r;

endmodule

// File: tb/tb_uart_rx.sv
// Directed plus randomized bench for uart_rx at 10 clocks per bit.
module tb_uart_rx;

    localparam int C = 10;

    logic clk = 1'b0;
    logic rst_n;
    logic rx_pin;
    logic frame_err;
    logic overrun_err;
    logic rx_busy;

    uart_rx_if bus ();

    uart_rx #(
        .CLK_FREQUENCY (1_000_000),
        .BAUD_RATE     (100_000)
    ) dut (
        .clk_in      (clk),
        .rst_n       (rst_n),
        .rx_pin      (rx_pin),
        .rx_bus      (bus),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .rx_busy     (rx_busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Observation counters, written only by the monitor below.
    int         cyc       = 0;
    int         last_rise = -1;
    int         fe_cnt    = 0;
    int         ovr_cnt   = 0;
    int         busy_cnt  = 0;
    logic       prev_valid = 1'b0;
    logic [7:0] got_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: record transfers, error pulses, busy cycles and rx_valid rises.
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1 && bus.rx_ready === 1'b1) got_q.push_back(bus.rx_data);
        if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
        if (overrun_err === 1'b1) ovr_cnt <= ovr_cnt + 1;
        if (rx_busy === 1'b1) busy_cnt <= busy_cnt + 1;
        if (bus.rx_valid === 1'b1 && prev_valid !== 1'b1) last_rise <= cyc;
        prev_valid <= bus.rx_valid;
    end

    // Watchdog so the run always ends.
    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one 8N1 frame. rx_ready is rdy_base, except 1 on tick ready_at.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic rdy_base, input int ready_at);
        logic [9:0] lv;
        lv = {stop, b, 1'b0};
        for (int k = 0; k < 10 * C; k++) begin
            rx_pin       = lv[k / C];
            bus.rx_ready = (k == ready_at) ? 1'b1 : rdy_base;
            tick();
        end
        rx_pin       = stop;
        bus.rx_ready = rdy_base;
    endtask

    task automatic drain();
        bus.rx_ready = 1'b1;
        tick();
        bus.rx_ready = 1'b0;
    endtask

    initial begin
        int         t0;
        int         base;
        int         fe0;
        int         ov0;
        int         bz0;
        logic [7:0] exp_q[$];
        logic       m_valid;
        logic [7:0] m_data;
        int         m_ovr;
        logic [7:0] rb;
        logic       rr;

        rst_n        = 1'b0;
        rx_pin       = 1'b1;
        bus.rx_ready = 1'b0;
        repeat (3) tick();
        check("reset_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("reset_data", {24'd0, bus.rx_data}, 32'd0);
        check("reset_busy", {31'd0, rx_busy}, 32'd0);
        check("reset_errs", {30'd0, frame_err, overrun_err}, 32'd0);
        rst_n = 1'b1;
        repeat (5) tick();

        // 1: single byte, latency and drain
        t0 = cyc;
        send_frame(8'hA5, 1'b1, 1'b0, -1);
        check("t1_latency_98pm1", {31'd0, (last_rise - t0 >= 97) && (last_rise - t0 <= 99)}, 32'd1);
        check("t1_valid", {31'd0, bus.rx_valid}, 32'd1);
        check("t1_data", {24'd0, bus.rx_data}, 32'hA5);
        base = got_q.size();
        drain();
        check("t1_valid_cleared", {31'd0, bus.rx_valid}, 32'd0);
        check("t1_xfer_count", got_q.size() - base, 32'd1);
        if (got_q.size() > base) check("t1_xfer_data", {24'd0, got_q[base]}, 32'hA5);
        repeat (5) tick();

        // 2: short low glitch is rejected
        fe0 = fe_cnt; bz0 = busy_cnt; base = got_q.size();
        rx_pin = 1'b0;
        repeat (3) tick();
        rx_pin = 1'b1;
        repeat (20) tick();
        check("t2_busy_seen", {31'd0, (busy_cnt - bz0) >= 1}, 32'd1);
        check("t2_busy_le6", {31'd0, (busy_cnt - bz0) <= 6}, 32'd1);
        check("t2_no_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("t2_no_frame_err", fe_cnt - fe0, 32'd0);
        check("t2_idle", {31'd0, rx_busy}, 32'd0);

        // 3: framing error, line held low, recovery
        fe0 = fe_cnt; ov0 = ovr_cnt;
        send_frame(8'h3C, 1'b0, 1'b0, -1);
        repeat (50) tick();
        check("t3_frame_err_once", fe_cnt - fe0, 32'd1);
        check("t3_no_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("t3_busy_in_break", {31'd0, rx_busy}, 32'd1);
        rx_pin = 1'b1;
        repeat (6) tick();
        check("t3_idle_after_break", {31'd0, rx_busy}, 32'd0);
        send_frame(8'h81, 1'b1, 1'b0, -1);
        check("t3_recover_valid", {31'd0, bus.rx_valid}, 32'd1);
        check("t3_recover_data", {24'd0, bus.rx_data}, 32'h81);
        check("t3_frame_err_total", fe_cnt - fe0, 32'd1);
        drain();
        repeat (5) tick();

        // 4: back-to-back frames, consumer always ready
        base = got_q.size(); fe0 = fe_cnt; ov0 = ovr_cnt;
        send_frame(8'h00, 1'b1, 1'b1, -1);
        send_frame(8'hFF, 1'b1, 1'b1, -1);
        send_frame(8'h55, 1'b1, 1'b1, -1);
        repeat (5) tick();
        bus.rx_ready = 1'b0;
        check("t4_xfer_count", got_q.size() - base, 32'd3);
        if (got_q.size() - base == 3) begin
            check("t4_byte0", {24'd0, got_q[base]}, 32'h00);
            check("t4_byte1", {24'd0, got_q[base + 1]}, 32'hFF);
            check("t4_byte2", {24'd0, got_q[base + 2]}, 32'h55);
        end
        check("t4_no_errs", (fe_cnt - fe0) + (ovr_cnt - ov0), 32'd0);

        // 5a: overrun keeps the old byte
        ov0 = ovr_cnt;
        send_frame(8'h11, 1'b1, 1'b0, -1);
        send_frame(8'h22, 1'b1, 1'b0, -1);
        repeat (3) tick();
        check("t5_overrun_once", ovr_cnt - ov0, 32'd1);
        check("t5_data_kept", {24'd0, bus.rx_data}, 32'h11);
        check("t5_valid_kept", {31'd0, bus.rx_valid}, 32'd1);
        drain();
        // 5b: drain on the byte-complete cycle avoids overrun
        ov0 = ovr_cnt; base = got_q.size();
        send_frame(8'h11, 1'b1, 1'b0, -1);
        send_frame(8'h22, 1'b1, 1'b0, 97);
        repeat (3) tick();
        check("t5_no_overrun", ovr_cnt - ov0, 32'd0);
        check("t5_new_data", {24'd0, bus.rx_data}, 32'h22);
        check("t5_new_valid", {31'd0, bus.rx_valid}, 32'd1);
        check("t5_old_xfer", got_q.size() - base, 32'd1);
        if (got_q.size() > base) check("t5_old_xfer_data", {24'd0, got_q[base]}, 32'h11);
        drain();
        repeat (5) tick();

        // 6: reset in the middle of a frame
        for (int k = 0; k < 5 * C + 5; k++) begin
            rx_pin = (k < 5 * C) ? 1'b0 : 1'b1;  // start + bits 0..3 of F0 are low
            tick();
        end
        check("t6_busy_before", {31'd0, rx_busy}, 32'd1);
        rst_n = 1'b0;
        tick();
        check("t6_rst_valid", {31'd0, bus.rx_valid}, 32'd0);
        check("t6_rst_data", {24'd0, bus.rx_data}, 32'd0);
        check("t6_rst_busy", {31'd0, rx_busy}, 32'd0);
        check("t6_rst_errs", {30'd0, frame_err, overrun_err}, 32'd0);
        rx_pin = 1'b1;
        tick();
        rst_n = 1'b1;
        base = got_q.size();
        repeat (20) tick();
        check("t6_idle_after", {31'd0, rx_busy}, 32'd0);
        send_frame(8'h5A, 1'b1, 1'b0, -1);
        check("t6_data", {24'd0, bus.rx_data}, 32'h5A);
        drain();
        check("t6_only_one", got_q.size() - base, 32'd1);
        if (got_q.size() > base) check("t6_only_5a", {24'd0, got_q[base]}, 32'h5A);
        repeat (5) tick();

        // Random frames against a buffer-level model of the consumer side.
        base = got_q.size(); ov0 = ovr_cnt; fe0 = fe_cnt;
        m_valid = 1'b0; m_data = 8'h00; m_ovr = 0;
        for (int i = 0; i < 10; i++) begin
            rb = 8'($urandom);
            rr = 1'($urandom_range(0, 1));
            send_frame(rb, 1'b1, rr, -1);
            if (rr) begin
                if (m_valid) exp_q.push_back(m_data);
                exp_q.push_back(rb);
                m_valid = 1'b0;
            end else if (m_valid) begin
                m_ovr++;
            end else begin
                m_valid = 1'b1;
                m_data  = rb;
            end
        end
        bus.rx_ready = 1'b0;
        tick();
        check("rand_valid", {31'd0, bus.rx_valid}, {31'd0, m_valid});
        if (m_valid) check("rand_held_data", {24'd0, bus.rx_data}, {24'd0, m_data});
        drain();
        if (m_valid) exp_q.push_back(m_data);
        check("rand_overruns", ovr_cnt - ov0, m_ovr);
        check("rand_no_frame_err", fe_cnt - fe0, 32'd0);
        check("rand_xfer_count", got_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < got_q.size()) check("rand_xfer_data", {24'd0, got_q[base + i]}, {24'd0, exp_q[i]});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
